nrzi_rx_decoder: RTL and testbench

//  Serial NRZI line decoder and byte deserializer. It is the receive end of
//  an inversion-based line code: a line transition decodes to 0, no

---
 rtl/nrzi_pkg.sv | 21 ++
 rtl/nrzi_bit_decoder.sv | 41 ++++
 rtl/nrzi_rx_decoder.sv | 138 +++++++++++++
 tb/tb_nrzi_rx_decoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/nrzi_pkg.sv
// ---------------------------------------------------------------------------
// nrzi_pkg
// Shared defaults and width helpers for the NRZI receive decoder.
//   DATA_W_DEF      default assembled word width
//   IDLE_LEVEL_DEF  line level assumed before the first sample
//   STUFF_LEN_DEF   run of decoded 1s after which a stuffed 0 is expected
//   cntWidth()      bits needed to hold the values 0..maxVal (at least 1)
// ---------------------------------------------------------------------------
package nrzi_pkg;

    localparam int   DATA_W_DEF     = 8;
    localparam logic IDLE_LEVEL_DEF = 1'b1;
    localparam int   STUFF_LEN_DEF  = 6;

    function automatic int cntWidth(input int maxVal);
        int w;
        w = $clog2(maxVal + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/nrzi_bit_decoder.sv
// ---------------------------------------------------------------------------
// nrzi_bit_decoder
// Holds the previous line level and turns each qualified line sample into a
// decoded bit. A transition decodes to 0 and a steady level decodes to 1.
// Ports:
//   i_clk       rising-edge clock
//   i_rst       synchronous active-high reset (previous level -> IDLE_LEVEL)
//   i_line_in   sampled line level
//   i_in_valid  line sample qualifier
//   o_d         decoded bit for the current sample (combinational)
//   o_d_valid   o_d is meaningful this cycle
// ---------------------------------------------------------------------------
module nrzi_bit_decoder
    import nrzi_pkg::*;
#(
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line_in,
    input  logic i_in_valid,
    output logic o_d,
    output logic o_d_valid
);

    logic r_prevLevel;

    // The previous level follows every valid sample, including samples whose
    // decoded bit is later thrown away, so the line history never breaks.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prevLevel <= IDLE_LEVEL;
        end else if (i_in_valid) begin
            r_prevLevel <= i_line_in;
        end
    end

    assign o_d       = ~(i_line_in ^ r_prevLevel);
    assign o_d_valid = i_in_valid;

endmodule

// File: rtl/nrzi_rx_decoder.sv
// ---------------------------------------------------------------------------
// nrzi_rx_decoder
// NRZI line decoder and LSB-first byte deserializer with optional
// bit-destuffing. Build option: define NRZI_DESTUFF_EN to enable destuffing
// (drop the bit after STUFF_LEN decoded 1s, flag a 1 in that slot as an
// error). Without it every decoded bit is accepted and o_stuff_err is 0.
// Ports:
//   i_clk         rising-edge clock
//   i_rst         synchronous active-high reset, wins over everything
//   i_line_in     sampled line level, qualified by i_in_valid
//   i_in_valid    one line sample per cycle when high
//   i_sync_clr    discard partial word and stuff count (beats i_in_valid)
//   o_data_out    last completed word, bit 0 = first decoded bit
//   o_data_valid  one-cycle pulse when o_data_out is updated
//   o_stuff_err   one-cycle pulse on a stuffing violation
// ---------------------------------------------------------------------------
module nrzi_rx_decoder
    import nrzi_pkg::*;
#(
    parameter int   DATA_W     = DATA_W_DEF,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF,
    parameter int   STUFF_LEN  = STUFF_LEN_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_line_in,
    input  logic              i_in_valid,
    input  logic              i_sync_clr,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_data_valid,
    output logic              o_stuff_err
);

    localparam int BIT_CNT_W = cntWidth(DATA_W - 1);

    logic                 w_d;
    logic                 w_dValid;
    logic                 w_stuffSlot;
    logic                 w_stuffViolation;
    logic                 w_accept;
    logic [DATA_W-1:0]    w_nextWord;
    logic                 w_unusedLsb;

    logic [DATA_W-1:0]    r_shreg;
    logic [BIT_CNT_W-1:0] r_bitCnt;
    logic [DATA_W-1:0]    r_dataOut;
    logic                 r_dataValid;

    nrzi_bit_decoder #(
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_bitDecoder (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_line_in  (i_line_in),
        .i_in_valid (i_in_valid),
        .o_d        (w_d),
        .o_d_valid  (w_dValid)
    );

`ifdef NRZI_DESTUFF_EN
    localparam int ONES_W = cntWidth(STUFF_LEN);

    logic [ONES_W-1:0] r_onesCnt;
    logic              r_stuffErr;

    // Once STUFF_LEN ones have been seen, the next decoded bit is the stuff
    // bit: it is never shifted in, and a 1 there breaks the current word.
    assign w_stuffSlot      = (r_onesCnt == ONES_W'(STUFF_LEN));
    assign w_stuffViolation = w_dValid & ~i_sync_clr & w_stuffSlot & w_d;

    // Run-length of decoded 1s; the stuff slot always restarts the run.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_sync_clr) begin
            r_onesCnt <= '0;
        end else if (w_dValid) begin
            if (w_stuffSlot || !w_d) begin
                r_onesCnt <= '0;
            end else begin
                r_onesCnt <= r_onesCnt + ONES_W'(1);
            end
        end
    end

    // Error pulse lasts one cycle; it can never coincide with data_valid
    // because a violating bit is never accepted into a word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stuffErr <= 1'b0;
        end else begin
            r_stuffErr <= w_stuffViolation;
        end
    end

    assign o_stuff_err = r_stuffErr;
`else
    logic w_unusedCfg;

    assign w_stuffSlot      = 1'b0;
    assign w_stuffViolation = 1'b0;
    assign o_stuff_err      = 1'b0;
    assign w_unusedCfg      = ^STUFF_LEN;
`endif

    assign w_accept    = w_dValid & ~i_sync_clr & ~w_stuffSlot;
    assign w_nextWord  = {w_d, r_shreg[DATA_W-1:1]};
    assign w_unusedLsb = r_shreg[0];

    // Shifter, bit counter and output word. The word completes on the
    // DATA_W-th accepted bit; the counter wraps so the next word starts on
    // the very next accepted sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shreg     <= '0;
            r_bitCnt    <= '0;
            r_dataOut   <= '0;
            r_dataValid <= 1'b0;
        end else begin
            r_dataValid <= 1'b0;
            if (i_sync_clr || w_stuffViolation) begin
                r_shreg  <= '0;
                r_bitCnt <= '0;
            end else if (w_accept) begin
                r_shreg <= w_nextWord;
                if (r_bitCnt == BIT_CNT_W'(DATA_W - 1)) begin
                    r_bitCnt    <= '0;
                    r_dataOut   <= w_nextWord;
                    r_dataValid <= 1'b1;
                end else begin
                    r_bitCnt <= r_bitCnt + BIT_CNT_W'(1);
                end
            end
        end
    end

    assign o_data_out   = r_dataOut;
    assign o_data_valid = r_dataValid;

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// ---------------------------------------------------------------------------
// tb_nrzi_rx_decoder
// Directed bench for nrzi_rx_decoder. Stimulus is given as decoded bits and
// NRZI-encoded on the fly (a 0 toggles the line, a 1 holds it). Build option
// NRZI_DESTUFF_EN selects the destuffing expectations.
// ---------------------------------------------------------------------------
module tb_nrzi_rx_decoder;

    logic       clk;
    logic       rst;
    logic       lineIn;
    logic       inValid;
    logic       syncClr;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       stuffErr;

    int         assertCount;
    int         failCount;
    logic       txLevel;
    logic [7:0] expData;

    nrzi_rx_decoder dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_line_in    (lineIn),
        .i_in_valid   (inValid),
        .i_sync_clr   (syncClr),
        .o_data_out   (dataOut),
        .o_data_valid (dataValid),
        .o_stuff_err  (stuffErr)
    );

    // 10 ns clock; inputs change and outputs are sampled 1 ns after each
    // rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and step past the next rising edge.
    task automatic applyStimulus(input logic line, input logic valid, input logic clr);
        lineIn  = line;
        inValid = valid;
        syncClr = clr;
        @(posedge clk);
        #1;
        if (valid) txLevel = line;
    endtask

    // Compare all three outputs against the expected pulse values and the
    // word the bench believes should currently be held on data_out.
    task automatic checkOutput(input string tag, input logic expValid, input logic expErr);
        assertCount++;
        assert (dataValid === expValid)
        else begin
            failCount++;
            $error("[TB] FAIL %s data_valid: observed %b expected %b", tag, dataValid, expValid);
        end
        assertCount++;
        assert (stuffErr === expErr)
        else begin
            failCount++;
            $error("[TB] FAIL %s stuff_err: observed %b expected %b", tag, stuffErr, expErr);
        end
        assertCount++;
        assert (dataOut === expData)
        else begin
            failCount++;
            $error("[TB] FAIL %s data_out: observed %h expected %h", tag, dataOut, expData);
        end
    endtask

    task automatic sendBit(input logic d);
        applyStimulus(d ? txLevel : ~txLevel, 1'b1, 1'b0);
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(txLevel, 1'b0, 1'b0);
        checkOutput(tag, 1'b0, 1'b0);
    endtask

    task automatic applyReset(input string tag);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expData = 8'h00;
        checkOutput(tag, 1'b0, 1'b0);
        rst     = 1'b0;
        txLevel = 1'b1;
    endtask

    // Send a word LSB first; valid must stay low until the 8th bit.
    task automatic sendWord(input string tag, input logic [7:0] word);
        for (int i = 0; i < 8; i++) begin
            sendBit(word[i]);
            if (i == 7) begin
                expData = word;
                checkOutput(tag, 1'b1, 1'b0);
            end else begin
                checkOutput(tag, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst         = 1'b0;
        lineIn      = 1'b1;
        inValid     = 1'b0;
        syncClr     = 1'b0;
        txLevel     = 1'b1;
        expData     = 8'h00;

        // Test 1: reset, then line held high for 8 samples.
        applyReset("reset");
`ifdef NRZI_DESTUFF_EN
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkOutput("t1_destuff", 1'b0, (i == 6));
        end
        idleCycle("t1_destuff_idle");
`else
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            if (i == 7) expData = 8'hFF;
            checkOutput("t1_allOnes", (i == 7), 1'b0);
        end
        idleCycle("t1_hold");
        idleCycle("t1_hold2");
`endif

        // Test 2: alternating line from the idle level -> all zeros.
        applyReset("t2_reset");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i[0], 1'b1, 1'b0);
            if (i == 7) expData = 8'h00;
            checkOutput("t2_alternate", (i == 7), 1'b0);
        end
        idleCycle("t2_hold");

        // Test 3: two words back to back with no idle between them.
        sendWord("t3_wordA5", 8'hA5);
        sendWord("t3_word3C", 8'h3C);
        idleCycle("t3_hold");

        // Test 6a: sync_clr together with a sample after 3 bits.
        sendBit(1'b1);
        checkOutput("t6_pre", 1'b0, 1'b0);
        sendBit(1'b1);
        checkOutput("t6_pre", 1'b0, 1'b0);
        sendBit(1'b1);
        checkOutput("t6_pre", 1'b0, 1'b0);
        applyStimulus(~txLevel, 1'b1, 1'b1);
        checkOutput("t6_syncClr", 1'b0, 1'b0);
        sendWord("t6_after_clr", 8'h5A);
        idleCycle("t6_hold");

        // Test 6b: reset after 5 bits discards the partial word.
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        checkOutput("t6_partial", 1'b0, 1'b0);
        applyReset("t6_reset");
        sendWord("t6_after_rst", 8'hC3);
        idleCycle("t6_hold2");

`ifdef NRZI_DESTUFF_EN
        // Test 4: six ones, stuffed zero, then 0,1 -> 8'hBF.
        applyReset("t4_reset");
        for (int i = 0; i < 6; i++) begin
            sendBit(1'b1);
            checkOutput("t4_ones", 1'b0, 1'b0);
        end
        sendBit(1'b0);
        checkOutput("t4_stuff", 1'b0, 1'b0);
        sendBit(1'b0);
        checkOutput("t4_bit6", 1'b0, 1'b0);
        sendBit(1'b1);
        expData = 8'hBF;
        checkOutput("t4_word", 1'b1, 1'b0);
        idleCycle("t4_hold");

        // Test 5: seven ones -> error, then a fresh word.
        applyReset("t5_reset");
        for (int i = 0; i < 7; i++) begin
            sendBit(1'b1);
            checkOutput("t5_ones", 1'b0, (i == 6));
        end
        sendWord("t5_fresh", 8'h5A);
        idleCycle("t5_hold");
`else
        // Without destuffing, a long run of ones is ordinary data.
        applyReset("t5_reset");
        for (int i = 0; i < 7; i++) begin
            sendBit(1'b1);
            checkOutput("t5_noDestuff", 1'b0, 1'b0);
        end
        sendBit(1'b0);
        expData = 8'h7F;
        checkOutput("t5_noDestuff_word", 1'b1, 1'b0);
        idleCycle("t5_hold");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
